// File: rtl/drac_pkg.sv
// Shared types for the scalar issue stage.
// Holds the per-entry issue descriptor handed from the instruction queue head
// to the issue controller, the functional-unit enumeration and the default
// in-flight limit.
package drac_pkg;

    localparam int NUM_SCALAR_INSTR     = 2;
    localparam int INFLIGHT_MAX_DEFAULT = 16;
    localparam int REG_W                = 5;

    typedef enum logic [2:0] {
        UNIT_ALU    = 3'd0,
        UNIT_BRANCH = 3'd1,
        UNIT_MEM    = 3'd2,
        UNIT_MUL    = 3'd3,
        UNIT_DIV    = 3'd4
    } unit_e;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [REG_W-1:0] rd;
        logic             use_rs1;
        logic             use_rs2;
        logic             regwr;
        unit_e            unit;
        logic             serial;
    } iq_issue_info_t;

    // Units whose results come back through the writeback ports and whose
    // pipelines cannot accept two instructions in the same cycle.
    function automatic logic is_long_lat(input unit_e u);
        return (u == UNIT_MEM) || (u == UNIT_MUL) || (u == UNIT_DIV);
    endfunction

endpackage

// File: rtl/issue_scoreboard.sv
// Busy-register scoreboard for long-latency results.
// Ports:
//   clk_i, rstn_i   clock, asynchronous active-low reset
//   flush_i         clears every busy bit on the next edge
//   set_valid_i/set_rd_i  mark a destination busy (one per issue slot)
//   clr_valid_i/clr_rd_i  writeback releases a destination (one per port)
//   busy_o          busy vector, bit 0 is hard-wired clear
module issue_scoreboard
    import drac_pkg::*;
#(
    parameter int NREGS = 32
) (
    input  logic                                   clk_i,
    input  logic                                   rstn_i,
    input  logic                                   flush_i,
    input  logic [NUM_SCALAR_INSTR-1:0]            set_valid_i,
    input  logic [NUM_SCALAR_INSTR-1:0][REG_W-1:0] set_rd_i,
    input  logic [NUM_SCALAR_INSTR-1:0]            clr_valid_i,
    input  logic [NUM_SCALAR_INSTR-1:0][REG_W-1:0] clr_rd_i,
    output logic [NREGS-1:0]                       busy_o
);

    logic [NREGS-1:0] busy_q, busy_d;

    // Clears are applied before sets so that a register issued and written
    // back in the same cycle stays busy for the newer producer.
    always_comb begin
        busy_d = busy_q;
        for (int r = 1; r < NREGS; r++) begin
            for (int k = 0; k < NUM_SCALAR_INSTR; k++) begin
                if (clr_valid_i[k] && (clr_rd_i[k] == REG_W'(r))) begin
                    busy_d[r] = 1'b0;
                end
            end
            for (int k = 0; k < NUM_SCALAR_INSTR; k++) begin
                if (set_valid_i[k] && (set_rd_i[k] == REG_W'(r))) begin
                    busy_d[r] = 1'b1;
                end
            end
        end
        busy_d[0] = 1'b0;
        if (flush_i) begin
            busy_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_o = busy_q;

endmodule

// File: rtl/iq_issue_ctrl.sv
// Dual-issue controller at the head of the instruction queue.
// Decides each cycle how many head entries (0, 1 or 2, oldest first) move to
// register read, tracks issued-but-uncommitted instructions, and sequences
// serializing instructions (drain, issue alone, wait for commit).
// Ports:
//   clk_i, rstn_i      clock, asynchronous active-low reset
//   flush_i            pipeline flush, blocks issue and clears all state
//   iq_empty_i, head_i queue status and the two oldest entries
//   rr_ready_i         per-slot downstream acceptance
//   commit_cnt_i       instructions retired this cycle
//   wb_valid_i/wb_rd_i long-latency writebacks releasing busy registers
//   read_head_o        per-slot pop strobes (combinational)
//   stall_o            oldest entry present but not issued
//   inflight_o         issued-but-uncommitted count
module iq_issue_ctrl
    import drac_pkg::*;
#(
    parameter int INFLIGHT_MAX = INFLIGHT_MAX_DEFAULT,
    parameter int NREGS        = 32
) (
    input  logic                                   clk_i,
    input  logic                                   rstn_i,
    input  logic                                   flush_i,
    input  logic                                   iq_empty_i,
    input  iq_issue_info_t [NUM_SCALAR_INSTR-1:0]  head_i,
    input  logic [NUM_SCALAR_INSTR-1:0]            rr_ready_i,
    input  logic [1:0]                             commit_cnt_i,
    input  logic [NUM_SCALAR_INSTR-1:0]            wb_valid_i,
    input  logic [NUM_SCALAR_INSTR-1:0][REG_W-1:0] wb_rd_i,
    output logic [NUM_SCALAR_INSTR-1:0]            read_head_o,
    output logic                                   stall_o,
    output logic [$clog2(INFLIGHT_MAX):0]          inflight_o
);

    localparam int CNT_W  = $clog2(INFLIGHT_MAX) + 1;
    localparam int CNT_W1 = CNT_W + 1;

    typedef enum logic [1:0] {
        S_RUN         = 2'd0,
        S_DRAIN       = 2'd1,
        S_SERIAL_WAIT = 2'd2
    } state_e;

    state_e                      state_q, state_d;
    logic [CNT_W-1:0]            inflight_q, inflight_d;
    logic [NREGS-1:0]            busy;
    logic [NUM_SCALAR_INSTR-1:0] issue;
    logic [NUM_SCALAR_INSTR-1:0] hazard;
    logic [NUM_SCALAR_INSTR-1:0] set_valid;
    logic [NUM_SCALAR_INSTR-1:0][REG_W-1:0] set_rd;
    logic                        head_present;
    logic                        pair_conflict;
    logic                        run_ok0, run_ok1;
    logic [CNT_W1-1:0]           sum_w;

    function automatic logic reg_busy(input logic [NREGS-1:0] b,
                                      input logic [REG_W-1:0] r);
        reg_busy = 1'b0;
        for (int i = 1; i < NREGS; i++) begin
            if (r == REG_W'(i)) begin
                reg_busy = b[i];
            end
        end
    endfunction

    always_comb begin
        for (int k = 0; k < NUM_SCALAR_INSTR; k++) begin
            hazard[k] = (head_i[k].use_rs1 && reg_busy(busy, head_i[k].rs1)) ||
                        (head_i[k].use_rs2 && reg_busy(busy, head_i[k].rs2)) ||
                        (head_i[k].regwr   && reg_busy(busy, head_i[k].rd));
        end
    end

    // The younger entry may not read or overwrite the older one's result in
    // the same cycle, nor share a non-pipelined long-latency unit with it.
    assign pair_conflict =
        (head_i[0].regwr && (head_i[0].rd != '0) &&
         ((head_i[1].use_rs1 && (head_i[1].rs1 == head_i[0].rd)) ||
          (head_i[1].use_rs2 && (head_i[1].rs2 == head_i[0].rd)) ||
          (head_i[1].regwr   && (head_i[1].rd  == head_i[0].rd)))) ||
        ((head_i[0].unit == head_i[1].unit) && is_long_lat(head_i[0].unit));

    assign head_present = !iq_empty_i && head_i[0].valid;

    assign run_ok0 = head_present && rr_ready_i[0] && !hazard[0] &&
                     (int'(inflight_q) < INFLIGHT_MAX) && !head_i[0].serial;

    assign run_ok1 = run_ok0 && head_i[1].valid && rr_ready_i[1] && !hazard[1] &&
                     !head_i[1].serial && (int'(inflight_q) + 2 <= INFLIGHT_MAX) &&
                     !pair_conflict;

    // A serializing head is never issued from RUN; it first waits for the
    // pipeline to empty, goes alone, then blocks issue until it has retired.
    always_comb begin
        state_d = state_q;
        issue   = '0;
        case (state_q)
            S_RUN: begin
                issue[0] = run_ok0;
                issue[1] = run_ok1;
                if (head_present && head_i[0].serial) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if ((inflight_q == '0) && rr_ready_i[0] && head_present) begin
                    issue[0] = 1'b1;
                    state_d  = S_SERIAL_WAIT;
                end
            end
            S_SERIAL_WAIT: begin
                if (inflight_q == '0) begin
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d = S_RUN;
            end
        endcase
        if (flush_i) begin
            issue   = '0;
            state_d = S_RUN;
        end
    end

    assign sum_w = {1'b0, inflight_q} + CNT_W1'(issue[0]) + CNT_W1'(issue[1]);

    always_comb begin
        inflight_d = inflight_q;
        if (flush_i) begin
            inflight_d = '0;
        end else if (sum_w < CNT_W1'(commit_cnt_i)) begin
            inflight_d = '0;
        end else begin
            inflight_d = CNT_W'(sum_w - CNT_W1'(commit_cnt_i));
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q    <= S_RUN;
            inflight_q <= '0;
        end else begin
            state_q    <= state_d;
            inflight_q <= inflight_d;
        end
    end

    underflow_chk: assert property (@(posedge clk_i) disable iff (!rstn_i || flush_i)
                                    sum_w >= CNT_W1'(commit_cnt_i));

    always_comb begin
        for (int k = 0; k < NUM_SCALAR_INSTR; k++) begin
            set_valid[k] = issue[k] && head_i[k].regwr && (head_i[k].rd != '0) &&
                           is_long_lat(head_i[k].unit);
            set_rd[k]    = head_i[k].rd;
        end
    end

    issue_scoreboard #(
        .NREGS (NREGS)
    ) u_scoreboard (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .flush_i     (flush_i),
        .set_valid_i (set_valid),
        .set_rd_i    (set_rd),
        .clr_valid_i (wb_valid_i),
        .clr_rd_i    (wb_rd_i),
        .busy_o      (busy)
    );

    assign read_head_o = issue & {NUM_SCALAR_INSTR{rstn_i}};
    assign stall_o     = rstn_i && head_present && !issue[0];
    assign inflight_o  = inflight_q;

endmodule

// File: tb/tb_iq_issue_ctrl.sv
// Self-checking bench for iq_issue_ctrl: directed scenarios followed by
// randomized traffic, every cycle compared against a behavioural model.
module tb_iq_issue_ctrl;
    import drac_pkg::*;

    localparam int IMAX = 16;

    logic                  clk_i = 1'b0;
    logic                  rstn_i;
    logic                  flush_i;
    logic                  iq_empty_i;
    iq_issue_info_t [1:0]  head_i;
    logic [1:0]            rr_ready_i;
    logic [1:0]            commit_cnt_i;
    logic [1:0]            wb_valid_i;
    logic [1:0][4:0]       wb_rd_i;
    logic [1:0]            read_head_o;
    logic                  stall_o;
    logic [4:0]            inflight_o;

    int checks = 0;
    int errors = 0;

    // reference model: instruction count, register busy flags and progress
    // of a pending serializing instruction
    int   mInflight;
    bit   mBusy [32];
    bit   mDraining;
    bit   mWaiting;

    logic [1:0] lastReadHead;
    logic       lastStall;

    iq_issue_ctrl #(.INFLIGHT_MAX(IMAX), .NREGS(32)) dut (
        .clk_i        (clk_i),
        .rstn_i       (rstn_i),
        .flush_i      (flush_i),
        .iq_empty_i   (iq_empty_i),
        .head_i       (head_i),
        .rr_ready_i   (rr_ready_i),
        .commit_cnt_i (commit_cnt_i),
        .wb_valid_i   (wb_valid_i),
        .wb_rd_i      (wb_rd_i),
        .read_head_o  (read_head_o),
        .stall_o      (stall_o),
        .inflight_o   (inflight_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic iq_issue_info_t mk(input logic [4:0] rs1, input logic [4:0] rs2,
                                          input logic [4:0] rd, input bit u1, input bit u2,
                                          input bit wr, input unit_e u, input bit ser);
        iq_issue_info_t e;
        e.valid = 1'b1; e.rs1 = rs1; e.rs2 = rs2; e.rd = rd;
        e.use_rs1 = u1; e.use_rs2 = u2; e.regwr = wr; e.unit = u; e.serial = ser;
        return e;
    endfunction

    function automatic iq_issue_info_t noEntry();
        iq_issue_info_t e;
        e = mk(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, UNIT_ALU, 1'b0);
        e.valid = 1'b0;
        return e;
    endfunction

    function automatic bit isLong(input unit_e u);
        return (u == UNIT_MEM) || (u == UNIT_MUL) || (u == UNIT_DIV);
    endfunction

    function automatic bit blocked(input iq_issue_info_t e);
        return (e.use_rs1 && mBusy[e.rs1]) || (e.use_rs2 && mBusy[e.rs2]) ||
               (e.regwr && mBusy[e.rd]);
    endfunction

    function automatic bit pairConflict(input iq_issue_info_t a, input iq_issue_info_t b);
        bit dep;
        dep = a.regwr && (a.rd != 0) &&
              ((b.use_rs1 && b.rs1 == a.rd) || (b.use_rs2 && b.rs2 == a.rd) ||
               (b.regwr && b.rd == a.rd));
        return dep || (a.unit == b.unit && isLong(a.unit));
    endfunction

    function automatic logic [1:0] modelPredict();
        logic [1:0] r;
        iq_issue_info_t a, b;
        r = 2'b00;
        a = head_i[0];
        b = head_i[1];
        if (!rstn_i || flush_i || iq_empty_i || !a.valid || mWaiting) return 2'b00;
        if (mDraining) return (mInflight == 0 && rr_ready_i[0]) ? 2'b01 : 2'b00;
        if (a.serial || !rr_ready_i[0] || blocked(a) || mInflight >= IMAX) return 2'b00;
        r[0] = 1'b1;
        if (b.valid && rr_ready_i[1] && !blocked(b) && !b.serial &&
            mInflight + 2 <= IMAX && !pairConflict(a, b)) r[1] = 1'b1;
        return r;
    endfunction

    task automatic modelAdvance(input logic [1:0] iss);
        int oldCount;
        int nxt;
        if (flush_i) begin
            mInflight = 0; mDraining = 0; mWaiting = 0;
            foreach (mBusy[i]) mBusy[i] = 0;
            return;
        end
        oldCount = mInflight;
        nxt = mInflight + int'(iss[0]) + int'(iss[1]) - int'(commit_cnt_i);
        if (nxt < 0) nxt = 0;
        if (mWaiting) begin
            if (oldCount == 0) mWaiting = 0;
        end else if (mDraining) begin
            if (iss[0]) begin mDraining = 0; mWaiting = 1; end
        end else if (!iq_empty_i && head_i[0].valid && head_i[0].serial) begin
            mDraining = 1;
        end
        for (int k = 0; k < 2; k++) if (wb_valid_i[k]) mBusy[wb_rd_i[k]] = 0;
        for (int k = 0; k < 2; k++)
            if (iss[k] && head_i[k].regwr && head_i[k].rd != 0 && isLong(head_i[k].unit))
                mBusy[head_i[k].rd] = 1;
        mInflight = nxt;
    endtask

    // One clock cycle with the inputs the caller has already placed.
    task automatic applyStimulus();
        logic [1:0] exp;
        logic       expStall;
        @(negedge clk_i);
        exp      = modelPredict();
        expStall = rstn_i && !iq_empty_i && head_i[0].valid && !exp[0];
        lastReadHead = read_head_o;
        lastStall    = stall_o;
        checkOutput("read_head", 32'(read_head_o), 32'(exp));
        checkOutput("stall", 32'(stall_o), 32'(expStall));
        checkOutput("inflight", 32'(inflight_o), 32'(mInflight));
        modelAdvance(exp);
        @(posedge clk_i);
        #1;
    endtask

    task automatic setIdle();
        flush_i = 0; iq_empty_i = 1; rr_ready_i = 2'b11; commit_cnt_i = 0;
        wb_valid_i = 0; wb_rd_i = '0;
        head_i[0] = noEntry(); head_i[1] = noEntry();
    endtask

    task automatic setPair(input iq_issue_info_t a, input iq_issue_info_t b);
        iq_empty_i = 0; head_i[0] = a; head_i[1] = b;
    endtask

    task automatic doReset();
        setPair(mk(5'd2, 5'd0, 5'd1, 1, 0, 1, UNIT_ALU, 0), mk(5'd4, 5'd0, 5'd3, 1, 0, 1, UNIT_ALU, 0));
        rstn_i = 0;
        #2;
        checkOutput("rst_read_head", 32'(read_head_o), 32'd0);
        checkOutput("rst_stall", 32'(stall_o), 32'd0);
        checkOutput("rst_inflight", 32'(inflight_o), 32'd0);
        mInflight = 0; mDraining = 0; mWaiting = 0;
        foreach (mBusy[i]) mBusy[i] = 0;
        @(posedge clk_i);
        #1;
        rstn_i = 1;
        setIdle();
    endtask

    task automatic drainAll();
        setIdle();
        for (int i = 0; i < 40 && (mInflight > 0 || mWaiting || mDraining); i++) begin
            commit_cnt_i = 2'(mInflight > 2 ? 2 : mInflight);
            applyStimulus();
        end
        commit_cnt_i = 0;
    endtask

    iq_issue_info_t aluA, aluB;

    initial begin
        rstn_i = 1;
        setIdle();
        @(posedge clk_i);
        #1;
        doReset();
        aluA = mk(5'd2, 5'd0, 5'd1, 1, 0, 1, UNIT_ALU, 0);
        aluB = mk(5'd4, 5'd0, 5'd3, 1, 0, 1, UNIT_ALU, 0);

        // independent pair issues together
        setPair(aluA, aluB);
        applyStimulus();
        checkOutput("pair_issue", 32'(lastReadHead), 32'd3);
        checkOutput("pair_inflight", 32'(inflight_o), 32'd2);
        drainAll();

        // RAW inside the pair holds the younger entry back one cycle
        setPair(mk(5'd1, 5'd0, 5'd5, 1, 0, 1, UNIT_ALU, 0), mk(5'd5, 5'd0, 5'd6, 1, 0, 1, UNIT_ALU, 0));
        applyStimulus();
        checkOutput("raw_split", 32'(lastReadHead), 32'd1);
        setPair(mk(5'd5, 5'd0, 5'd6, 1, 0, 1, UNIT_ALU, 0), noEntry());
        applyStimulus();
        checkOutput("raw_follow", 32'(lastReadHead), 32'd1);
        drainAll();

        // long-latency producer blocks its consumer until writeback
        setPair(mk(5'd1, 5'd2, 5'd7, 1, 1, 1, UNIT_DIV, 0), noEntry());
        applyStimulus();
        checkOutput("div_issue", 32'(lastReadHead), 32'd1);
        setPair(mk(5'd7, 5'd0, 5'd8, 1, 0, 1, UNIT_ALU, 0), noEntry());
        applyStimulus();
        checkOutput("div_stall1", 32'(lastStall), 32'd1);
        applyStimulus();
        checkOutput("div_stall2", 32'(lastStall), 32'd1);
        wb_valid_i = 2'b01; wb_rd_i[0] = 5'd7;
        applyStimulus();
        checkOutput("div_stall_wb", 32'(lastStall), 32'd1);
        wb_valid_i = 2'b00;
        applyStimulus();
        checkOutput("div_release", 32'(lastReadHead), 32'd1);
        drainAll();

        // serializing instruction: drain, go alone, wait for retirement
        setPair(aluA, aluB);
        applyStimulus();
        setPair(aluA, noEntry());
        applyStimulus();
        checkOutput("ser_pre_inflight", 32'(inflight_o), 32'd3);
        setPair(mk(5'd1, 5'd0, 5'd10, 1, 0, 1, UNIT_ALU, 1), mk(5'd12, 5'd0, 5'd11, 1, 0, 1, UNIT_ALU, 0));
        commit_cnt_i = 1;
        applyStimulus();
        checkOutput("ser_run_hold", 32'(lastReadHead), 32'd0);
        applyStimulus();
        checkOutput("ser_drain1", 32'(lastReadHead), 32'd0);
        applyStimulus();
        checkOutput("ser_drain2", 32'(lastReadHead), 32'd0);
        commit_cnt_i = 0;
        applyStimulus();
        checkOutput("ser_alone", 32'(lastReadHead), 32'd1);
        setPair(mk(5'd12, 5'd0, 5'd11, 1, 0, 1, UNIT_ALU, 0), mk(5'd14, 5'd0, 5'd13, 1, 0, 1, UNIT_ALU, 0));
        applyStimulus();
        checkOutput("ser_wait", 32'(lastReadHead), 32'd0);
        commit_cnt_i = 1;
        applyStimulus();
        commit_cnt_i = 0;
        for (int i = 0; i < 4 && lastReadHead == 2'b00; i++) applyStimulus();
        checkOutput("ser_resume", 32'(lastReadHead), 32'd3);
        drainAll();

        // in-flight limit, then flush while draining
        for (int i = 0; i < 7; i++) begin
            setPair(aluA, aluB);
            applyStimulus();
        end
        setPair(mk(5'd1, 5'd2, 5'd9, 1, 1, 1, UNIT_DIV, 0), noEntry());
        applyStimulus();
        checkOutput("lim_inflight15", 32'(inflight_o), 32'd15);
        setPair(aluA, aluB);
        applyStimulus();
        checkOutput("lim_single", 32'(lastReadHead), 32'd1);
        setPair(mk(5'd1, 5'd0, 5'd10, 1, 0, 1, UNIT_ALU, 1), aluB);
        applyStimulus();
        commit_cnt_i = 2;
        applyStimulus();
        commit_cnt_i = 0;
        flush_i = 1;
        applyStimulus();
        checkOutput("flush_block", 32'(lastReadHead), 32'd0);
        flush_i = 0;
        checkOutput("flush_inflight", 32'(inflight_o), 32'd0);
        setPair(mk(5'd9, 5'd0, 5'd20, 1, 0, 1, UNIT_ALU, 0), mk(5'd22, 5'd0, 5'd21, 1, 0, 1, UNIT_ALU, 0));
        applyStimulus();
        checkOutput("flush_resume", 32'(lastReadHead), 32'd3);
        drainAll();

        // reset in the middle of a drain abandons the serial sequence
        setPair(aluA, aluB);
        applyStimulus();
        setPair(mk(5'd1, 5'd0, 5'd10, 1, 0, 1, UNIT_ALU, 1), aluB);
        applyStimulus();
        applyStimulus();
        doReset();
        setPair(aluA, aluB);
        applyStimulus();
        checkOutput("rst_abort_serial", 32'(lastReadHead), 32'd3);
        drainAll();

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            iq_issue_info_t e [2];
            int maxC;
            for (int k = 0; k < 2; k++) begin
                e[k].valid   = ($urandom_range(0, 9) != 0);
                e[k].rs1     = 5'($urandom_range(0, 7));
                e[k].rs2     = 5'($urandom_range(0, 7));
                e[k].rd      = 5'($urandom_range(0, 7));
                e[k].use_rs1 = 1'($urandom_range(0, 1));
                e[k].use_rs2 = 1'($urandom_range(0, 1));
                e[k].regwr   = 1'($urandom_range(0, 1));
                e[k].unit    = unit_e'(3'($urandom_range(0, 4)));
                e[k].serial  = ($urandom_range(0, 24) == 0);
            end
            head_i[0]  = e[0];
            head_i[1]  = e[1];
            iq_empty_i = ($urandom_range(0, 9) == 0);
            rr_ready_i[0] = ($urandom_range(0, 6) != 0);
            rr_ready_i[1] = ($urandom_range(0, 6) != 0);
            maxC = (mInflight > 2) ? 2 : mInflight;
            commit_cnt_i = 2'($urandom_range(0, maxC));
            for (int k = 0; k < 2; k++) begin
                wb_valid_i[k] = ($urandom_range(0, 3) == 0);
                wb_rd_i[k]    = 5'($urandom_range(0, 7));
            end
            flush_i = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 499) == 0) doReset();
            else applyStimulus();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
